// File: rtl/cmult_rr_scheduler.sv
// rtl/cmult_rr_scheduler.sv - round-robin issue and tag tracking for a shared pipelined complex multiplier
module cmult_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int AWIDTH  = 18,
  parameter int BWIDTH  = 18,
  parameter int MUL_LAT = 6,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pause,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ*AWIDTH-1:0]           req_ar,
  input  logic [NREQ*AWIDTH-1:0]           req_ai,
  input  logic [NREQ*BWIDTH-1:0]           req_br,
  input  logic [NREQ*BWIDTH-1:0]           req_bi,
  output logic [AWIDTH-1:0]                mul_ar,
  output logic [AWIDTH-1:0]                mul_ai,
  output logic [BWIDTH-1:0]                mul_br,
  output logic [BWIDTH-1:0]                mul_bi,
  input  logic [AWIDTH+BWIDTH:0]           mul_pr,
  input  logic [AWIDTH+BWIDTH:0]           mul_pi,
  output logic [NREQ-1:0]                  rsp_valid,
  output logic [IDW-1:0]                   rsp_id,
  output logic [AWIDTH+BWIDTH:0]           rsp_pr,
  output logic [AWIDTH+BWIDTH:0]           rsp_pi,
  output logic [$clog2(MUL_LAT+3)-1:0]     inflight,
  output logic                             idle
);

  localparam int IFW = $clog2(MUL_LAT+3);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic           found;
  logic           grant;
  logic [IDW-1:0] ptr_next;

  // Entry 0 is the issue tag, entries 1..MUL_LAT track the multiplier stages.
  tag_t tag_sr [MUL_LAT+1];
  tag_t tag_out;

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found  = 1'b1;
        gnt_id = IDW'((int'(ptr) + k) % NREQ);
      end
    end
    grant     = found && !pause && rst_n;
    req_ready = '0;
    if (grant) req_ready[gnt_id] = 1'b1;
  end

  assign ptr_next = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
  assign tag_out  = tag_sr[MUL_LAT];
  assign idle     = (inflight == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      for (int k = 0; k <= MUL_LAT; k++) tag_sr[k] <= '0;
      mul_ar    <= '0;
      mul_ai    <= '0;
      mul_br    <= '0;
      mul_bi    <= '0;
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_pr    <= '0;
      rsp_pi    <= '0;
      inflight  <= '0;
    end else begin
      if (grant) ptr <= ptr_next;

      tag_sr[0] <= grant ? tag_t'{v: 1'b1, id: gnt_id} : tag_t'('0);
      for (int k = 1; k <= MUL_LAT; k++) tag_sr[k] <= tag_sr[k-1];

      if (grant) begin
        mul_ar <= req_ar[gnt_id*AWIDTH +: AWIDTH];
        mul_ai <= req_ai[gnt_id*AWIDTH +: AWIDTH];
        mul_br <= req_br[gnt_id*BWIDTH +: BWIDTH];
        mul_bi <= req_bi[gnt_id*BWIDTH +: BWIDTH];
      end else begin
        mul_ar <= '0;
        mul_ai <= '0;
        mul_br <= '0;
        mul_bi <= '0;
      end

      rsp_valid <= tag_out.v ? (NREQ'(1) << tag_out.id) : '0;
      rsp_id    <= tag_out.id;
      // Stale products from discarded operations never pass without a valid tag.
      if (tag_out.v) begin
        rsp_pr <= mul_pr;
        rsp_pi <= mul_pi;
      end

      case ({grant, |rsp_valid})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
